// File: rtl/postfix_eval_p_if.sv
// Token/result bundle for the postfix evaluator: the driver is the master,
// the evaluator is the slave.
interface postfix_eval_p_if #(
  parameter int DATA_W = 16,
  parameter int IN_W   = 4
);
  logic [IN_W-1:0]   IN;
  logic              IN_VALID;
  logic              OP_MODE;
  logic [DATA_W-1:0] OUT;
  logic              OUT_VALID;
  logic [2:0]        ERR;
  logic              BUSY;

  modport master (
    output IN, IN_VALID, OP_MODE,
    input  OUT, OUT_VALID, ERR, BUSY
  );

  modport slave (
    input  IN, IN_VALID, OP_MODE,
    output OUT, OUT_VALID, ERR, BUSY
  );
endinterface

// File: rtl/postfix_eval_p.sv
// Parametrised postfix (RPN) expression evaluator with an explicit stack,
// sticky first-error reporting and a one-cycle registered result strobe.
module postfix_eval_p #(
  parameter int DATA_W = 16,
  parameter int IN_W   = 4,
  parameter int DEPTH  = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  postfix_eval_p_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] E_OK      = 3'd0;
  localparam logic [2:0] E_UNDER   = 3'd1;
  localparam logic [2:0] E_OVER    = 3'd2;
  localparam logic [2:0] E_ILLEGAL = 3'd3;
  localparam logic [2:0] E_UNBAL   = 3'd4;

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, ERROR} state_t;

  // Opcode is one-hot in the low nibble; any upper token bit set is illegal.
  function automatic logic op_legal(input logic [IN_W-1:0] tok);
    logic [IN_W-1:0] hi;
    hi = tok >> 4;
    return (hi == '0) &&
           (tok[3:0] inside {4'b0001, 4'b0010, 4'b0100, 4'b1000});
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [3:0]        opc,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (opc)
      4'b0001: r = a + b;
      4'b0010: r = a - b;
      4'b0100: r = a * b;
      default: r = (a > b) ? a : b;
    endcase
    return r;
  endfunction

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [2:0]        err_q, err_nxt;

  logic [DATA_W-1:0] stack [DEPTH];

  logic [IDX_W-1:0]  idx_a, idx_b, idx_push, wr_idx;
  logic [DATA_W-1:0] opnd_a, opnd_b, wr_data;
  logic              wr_en;
  logic [2:0]        tok_err;
  logic              finish;

  logic [DATA_W-1:0] out_p1, out_nxt;
  logic              vld_p1, vld_nxt;
  logic [2:0]        err_p1, errout_nxt;

  // Token decode: operand addresses and the fault this token would raise.
  always_comb begin
    idx_a    = IDX_W'(ptr - PTR_W'(2));
    idx_b    = IDX_W'(ptr - PTR_W'(1));
    idx_push = IDX_W'(ptr);
    opnd_a   = stack[idx_a];
    opnd_b   = stack[idx_b];
    tok_err  = E_OK;
    if (bus.OP_MODE) begin
      if (!op_legal(bus.IN))
        tok_err = E_ILLEGAL;
      else if (ptr < PTR_W'(2))
        tok_err = E_UNDER;
    end else if (ptr == PTR_FULL) begin
      tok_err = E_OVER;
    end
    finish = !bus.IN_VALID && (state != IDLE);
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    err_nxt    = err_q;
    out_nxt    = '0;
    vld_nxt    = 1'b0;
    errout_nxt = E_OK;
    wr_en      = 1'b0;
    wr_idx     = idx_push;
    wr_data    = DATA_W'(bus.IN);

    case (state)
      IDLE, ACCUM: begin
        if (bus.IN_VALID) begin
          if (tok_err != E_OK) begin
            err_nxt   = tok_err;
            state_nxt = ERROR;
          end else begin
            state_nxt = ACCUM;
            wr_en     = 1'b1;
            if (bus.OP_MODE) begin
              wr_idx  = idx_a;
              wr_data = alu(bus.IN[3:0], opnd_a, opnd_b);
              ptr_nxt = ptr - PTR_W'(1);
            end else begin
              ptr_nxt = ptr + PTR_W'(1);
            end
          end
        end
      end
      ERROR:   ;
      default: state_nxt = IDLE;
    endcase

    // End of expression: report, then return to IDLE with a clean stack.
    if (finish) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
      err_nxt   = E_OK;
      vld_nxt   = 1'b1;
      if (err_q != E_OK)
        errout_nxt = err_q;
      else if (ptr != PTR_W'(1))
        errout_nxt = E_UNBAL;
      else
        out_nxt = stack[0];
    end
  end

  // Stage 1: control state and registered result outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      ptr    <= '0;
      err_q  <= E_OK;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
      err_p1 <= E_OK;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      err_q  <= err_nxt;
      out_p1 <= out_nxt;
      vld_p1 <= vld_nxt;
      err_p1 <= errout_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en)
      stack[wr_idx] <= wr_data;
  end

  assign bus.OUT       = out_p1;
  assign bus.OUT_VALID = vld_p1;
  assign bus.ERR       = err_p1;
  assign bus.BUSY      = (state != IDLE);

endmodule

// File: tb/tb_postfix_eval_p.sv
// Bench for postfix_eval_p: a default instance and a shallow, wide-token
// instance share one token stream and are checked every cycle against a model.
module tb_postfix_eval_p;

  typedef logic [6:0] tok_t;  // {op_mode, 6-bit token}

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       iv     = 1'b0;
  logic       opm    = 1'b0;
  logic [5:0] tok_in = '0;

  int n_tests = 0;
  int n_fail  = 0;

  postfix_eval_p_if #(.DATA_W(16), .IN_W(4)) bus_a ();
  postfix_eval_p_if #(.DATA_W(16), .IN_W(6)) bus_b ();

  assign bus_a.IN       = tok_in[3:0];
  assign bus_a.IN_VALID = iv;
  assign bus_a.OP_MODE  = opm;
  assign bus_b.IN       = tok_in;
  assign bus_b.IN_VALID = iv;
  assign bus_b.OP_MODE  = opm;

  postfix_eval_p #(.DATA_W(16), .IN_W(4), .DEPTH(16)) dut_a (
    .CLK(clk), .RESET(rst_n), .bus(bus_a));
  postfix_eval_p #(.DATA_W(16), .IN_W(6), .DEPTH(4)) dut_b (
    .CLK(clk), .RESET(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Evaluate a whole expression with a plain stack; tokens are masked to inw bits.
  function automatic void eval_expr(input tok_t q[$], input int depth, input int inw,
                                    output int unsigned res, output int unsigned err);
    longint unsigned st[$];
    longint unsigned a, b, r;
    int unsigned     v;
    err = 0;
    foreach (q[i]) begin
      if (err == 0) begin
        v = int'(q[i][5:0]) & ((1 << inw) - 1);
        if (q[i][6]) begin
          if (!(v inside {1, 2, 4, 8})) err = 3;
          else if (st.size() < 2) err = 1;
          else begin
            b = st.pop_back();
            a = st.pop_back();
            case (v)
              1:       r = a + b;
              2:       r = a - b;
              4:       r = a * b;
              default: r = (a > b) ? a : b;
            endcase
            st.push_back(r & 64'hFFFF);
          end
        end else if (st.size() == depth) err = 2;
        else st.push_back(longint'(v));
      end
    end
    res = 0;
    if (err == 0) begin
      if (st.size() != 1) err = 4;
      else res = int'(st[0]);
    end
  endfunction

  // Model of expression framing plus per-cycle output compare.
  tok_t        toks[$];
  bit          in_expr = 0;
  bit          e_vld, e_busy;
  int unsigned e_out_a, e_err_a, e_out_b, e_err_b;

  always @(posedge clk) begin
    e_vld = 0; e_out_a = 0; e_err_a = 0; e_out_b = 0; e_err_b = 0;
    if (!rst_n) begin
      in_expr = 0;
      toks.delete();
    end else if (iv) begin
      if (!in_expr) toks.delete();
      in_expr = 1;
      toks.push_back({opm, tok_in});
    end else if (in_expr) begin
      eval_expr(toks, 16, 4, e_out_a, e_err_a);
      eval_expr(toks, 4, 6, e_out_b, e_err_b);
      e_vld   = 1;
      in_expr = 0;
    end
    e_busy = in_expr;
    #1;
    chk("a.OUT_VALID", bus_a.OUT_VALID, e_vld);
    chk("a.OUT",       bus_a.OUT,       e_out_a);
    chk("a.ERR",       bus_a.ERR,       e_err_a);
    chk("a.BUSY",      bus_a.BUSY,      e_busy);
    chk("b.OUT_VALID", bus_b.OUT_VALID, e_vld);
    chk("b.OUT",       bus_b.OUT,       e_out_b);
    chk("b.ERR",       bus_b.ERR,       e_err_b);
    chk("b.BUSY",      bus_b.BUSY,      e_busy);
  end

  task automatic push(input int v);
    opm = 1'b0; tok_in = v[5:0]; iv = 1'b1;
    @(negedge clk);
  endtask

  task automatic op(input int c);
    opm = 1'b1; tok_in = c[5:0]; iv = 1'b1;
    @(negedge clk);
  endtask

  task automatic fin();
    iv = 1'b0; opm = 1'($urandom); tok_in = 6'($urandom);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    iv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called right after fin(): the end edge has just registered the result.
  task automatic expect_res(input string name, input int oa, input int ea,
                            input int ob, input int eb);
    chk({name, " a.vld"}, bus_a.OUT_VALID, 1);
    chk({name, " a.out"}, bus_a.OUT, oa);
    chk({name, " a.err"}, bus_a.ERR, ea);
    chk({name, " b.vld"}, bus_b.OUT_VALID, 1);
    chk({name, " b.out"}, bus_b.OUT, ob);
    chk({name, " b.err"}, bus_b.ERR, eb);
  endtask

  initial begin
    int depth_est;
    int r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset a.OUT_VALID", bus_a.OUT_VALID, 0);
    chk("reset a.OUT", bus_a.OUT, 0);
    chk("reset a.ERR", bus_a.ERR, 0);
    chk("reset a.BUSY", bus_a.BUSY, 0);
    rst_n = 1'b1;
    idle(1);

    push(3); push(4); op(1); push(2); op(4); fin();
    expect_res("t1", 14, 0, 14, 0);
    idle(1);
    chk("t1 pulse end", bus_a.OUT_VALID, 0);
    chk("t1 out clears", bus_a.OUT, 0);

    push(2); push(5); op(2); push(9); op(8); fin();
    expect_res("t2 sub/max", 65533, 0, 65533, 0);
    idle(1);

    repeat (5) push(15);
    repeat (4) op(4);
    fin();
    expect_res("t2 pow", 38479, 0, 0, 2);
    idle(2);

    push(3); op(1); fin();
    expect_res("t3 under", 0, 1, 0, 1);
    push(1); push(2); fin();
    expect_res("t3 unbal", 0, 4, 0, 4);
    push(1); push(1); op(3); push(1); fin();
    expect_res("t3 illegal", 0, 3, 0, 3);
    push(1); push(1); op(17); fin();
    expect_res("t3 upper bits", 2, 0, 0, 3);
    idle(1);

    for (int i = 1; i <= 5; i++) push(i);
    repeat (4) op(1);
    fin();
    expect_res("t4 overflow", 15, 0, 0, 2);

    push(6); push(7); op(4); fin();
    expect_res("t5 first", 42, 0, 42, 0);
    push(1); push(1); op(1); fin();
    expect_res("t5 second", 2, 0, 2, 0);

    push(5); fin();
    expect_res("t6 pre", 5, 0, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async a.OUT_VALID", bus_a.OUT_VALID, 0);
    chk("t6 async a.OUT", bus_a.OUT, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(9); push(9);
    iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async a.BUSY", bus_a.BUSY, 0);
    chk("t6 async b.BUSY", bus_b.BUSY, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    push(8); fin();
    expect_res("t6 after reset", 8, 0, 8, 0);
    idle(2);

    repeat (300) begin
      depth_est = 0;
      for (int k = 0; k < $urandom_range(1, 8); k++) begin
        r = $urandom_range(0, 19);
        if (r == 0) op($urandom_range(0, 63));
        else if (depth_est >= 2 && r < 10) begin
          op(1 << $urandom_range(0, 3));
          depth_est--;
        end else begin
          push($urandom_range(0, 63));
          depth_est++;
        end
      end
      fin();
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
